mrd_rdx_wrback: RTL and testbench
=================================

MRD_RDX_WRBACK -- requirements
Module: mrd_rdx_wrback

Interface
REQ-001 Parameter wData, default 30: width of each real/imag lane sample.
REQ-002 Parameter wAddr, default 8: bank address width.
REQ-003 Parameter wCnt, default 12: point-counter width.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  synchronous active-high reset; the name is kept from the codebase, and the port is asserted high.
REQ-006 cfg_start  in  1  one-cycle pulse that arms a new stage.
REQ-007 cfg_total  in  wCnt  points expected in the stage; sampled on cfg_start.
REQ-008 in_val  in  1  beat valid, driven by the radix/twiddle stage output.
REQ-009 in_factor  in  3  lanes valid in this beat, 2..5; lanes 0..in_factor-1 are used.
REQ-010 in_bank_index  in  [0:4][2:0]  target bank per lane.
REQ-011 in_bank_addr  in  [0:4][wAddr-1:0]  target address per lane.
REQ-012 in_real, in_imag  in  [0:4][wData-1:0]  signed lane data.
REQ-013 wr_en  out  5  per-bank write enable.
REQ-014 wr_addr  out  [0:4][wAddr-1:0]  per-bank write address.
REQ-015 wr_real, wr_imag  out  [0:4][wData-1:0]  per-bank write data.
REQ-016 busy  out  1  stage armed and not yet complete.
REQ-017 stage_done  out  1  one-cycle completion pulse.
REQ-018 err_overrun  out  1  sticky: beat received while idle, or point count exceeded cfg_total.
REQ-019 err_factor  out  1  sticky: beat received with in_factor outside 2..5.
REQ-020 err_conflict  out  1  sticky: two used lanes in one beat targeted the same bank.

Function
REQ-021 The block SHALL have two states: IDLE and RUN.
REQ-022 In IDLE, cfg_start SHALL latch cfg_total, clear the point counter, and enter RUN.
REQ-023 In RUN, each accepted beat SHALL add in_factor to the point counter.
REQ-024 The block SHALL pulse stage_done and return to IDLE in the cycle after the counter reaches or passes the latched total.
REQ-025 cfg_start in RUN SHALL restart the stage: the counter is cleared, the new total is latched, and no done pulse is issued.
REQ-026 cfg_start and in_val in the same cycle SHALL count the beat into the new stage, so the counter becomes in_factor.
REQ-027 A beat arriving in IDLE without cfg_start SHALL be dropped: no write occurs, and err_overrun is set.
REQ-028 A count that passes the total SHALL still write the beat in full, then set err_overrun, pulse stage_done, and return to IDLE.
REQ-029 A beat with in_factor outside 2..5 SHALL produce no writes, leave the counter unchanged, and set err_factor.
REQ-030 Routing: for each used lane k, bank in_bank_index[k] SHALL receive that lane's address and data, with its wr_en bit set.
REQ-031 A bank index greater than 4 SHALL be ignored for that lane.
REQ-032 Banks not targeted by any used lane SHALL have wr_en low; their wr_addr/wr_real/wr_imag hold previous values.
REQ-033 When two used lanes target the same bank, the lower-numbered lane SHALL win.
REQ-034 Latency SHALL be exactly 1 cycle: beat at edge N, write outputs valid after edge N+1; all outputs are registered.
REQ-035 Data SHALL pass through unmodified, with no rounding or width change.
REQ-036 busy SHALL be high exactly while in RUN.

Reset
REQ-037 While rst_n is high at a clock edge, the block SHALL enter IDLE and zero all of the following: counter, latched total, wr_en, wr_addr, wr_real, wr_imag, busy, stage_done, and all error flags.
REQ-038 Reset mid-stage SHALL abort the stage with no done pulse; beats arriving in that cycle are discarded.
REQ-039 The sticky error flags SHALL clear only on reset.

Configuration
REQ-040 With macro MRD_WRBACK_CONFLICT_CHK_EN defined, same-bank conflicts among used lanes SHALL be detected and SHALL set err_conflict.
REQ-041 Without the macro, err_conflict SHALL be constant 0, with no detection logic; lower-lane-wins routing is unchanged.

Verification
REQ-042 Reset, then cfg_start with total=12, then three beats with factor=4 and bank_index 0..3 -> counter sequence 4/8/12; stage_done pulses once on the cycle after the third beat's write; busy falls the same cycle.
REQ-043 Single beat, factor=5, bank_index={3,0,4,1,2}, addr={10,11,12,13,14} -> next cycle: wr_en=5'b11111, bank3 addr 10, bank0 addr 11, bank4 addr 12, bank1 addr 13, bank2 addr 14; data matches lane for lane.
REQ-044 Beat with factor=3, bank_index={2,2,1}, macro defined -> bank2 gets lane0 data, bank1 gets lane2 data, wr_en=5'b00110, err_conflict=1; with the macro undefined, the same writes occur and err_conflict=0.
REQ-045 in_val while IDLE, then factor=7 inside RUN -> no wr_en in either case; err_overrun=1 after the first, err_factor=1 after the second; the counter is unchanged.
REQ-046 total=10 with factor-4 beats, plus cfg_start with total=6 coinciding with the second beat -> counter resets to 4; stage_done pulses after the next beat (count 8 ≥ 6); err_overrun=1.
REQ-047 rst_n asserted mid-stage after one beat -> next cycle all outputs are 0, busy=0, no stage_done; a later beat without cfg_start sets err_overrun.

Source files
------------

// File: rtl/mrd_rdx_wrback.sv
// Radix-stage write-back router: steers up to five lanes per beat into banks.
// Optional same-bank conflict flag: define MRD_WRBACK_CONFLICT_CHK_EN.
module mrd_rdx_wrback #(
  parameter int wData = 30,
  parameter int wAddr = 8,
  parameter int wCnt  = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_start,
  input  logic [wCnt-1:0]        cfg_total,
  input  logic                   in_val,
  input  logic [2:0]             in_factor,
  input  logic [0:4][2:0]        in_bank_index,
  input  logic [0:4][wAddr-1:0]  in_bank_addr,
  input  logic [0:4][wData-1:0]  in_real,
  input  logic [0:4][wData-1:0]  in_imag,
  output logic [4:0]             wr_en,
  output logic [0:4][wAddr-1:0]  wr_addr,
  output logic [0:4][wData-1:0]  wr_real,
  output logic [0:4][wData-1:0]  wr_imag,
  output logic                   busy,
  output logic                   stage_done,
  output logic                   err_overrun,
  output logic                   err_factor,
  output logic                   err_conflict
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  logic [wCnt-1:0]      cnt_q, cnt_d;
  logic [wCnt-1:0]      total_q, total_d;
  logic [wCnt:0]        sum, base, lim;
  logic [4:0]           used;
  logic                 fac_ok, accept;
  logic                 done_d, ovr_d, fac_d;
  logic [4:0]           en_d;
  logic [0:4][wAddr-1:0] addr_d;
  logic [0:4][wData-1:0] re_d, im_d;

  always_comb begin
    fac_ok = (in_factor >= 3'd2) && (in_factor <= 3'd5);
    for (int k = 0; k < 5; k++) used[k] = 3'(k) < in_factor;
    accept = in_val && fac_ok && (cfg_start || state_q == RUN);
    base = cfg_start ? '0 : {1'b0, cnt_q};
    lim  = cfg_start ? {1'b0, cfg_total} : {1'b0, total_q};
    sum  = base;
    if (accept) sum = base + {{(wCnt-2){1'b0}}, in_factor};

    state_d = state_q;
    cnt_d   = cnt_q;
    total_d = total_q;
    done_d  = 1'b0;
    ovr_d   = err_overrun;
    fac_d   = err_factor;

    // a restart wins over completion, so no done pulse on restart
    if (cfg_start) begin
      state_d = RUN;
      total_d = cfg_total;
      cnt_d   = sum[wCnt-1:0];
    end else if (state_q == RUN) begin
      cnt_d = sum[wCnt-1:0];
      if (cnt_q >= total_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end

    if (accept && sum > lim) ovr_d = 1'b1;
    if (in_val && !cfg_start && state_q == IDLE) ovr_d = 1'b1;
    if (in_val && !fac_ok) fac_d = 1'b1;
  end

  // descending lane order lets the lowest lane overwrite a shared bank
  always_comb begin
    en_d   = '0;
    addr_d = wr_addr;
    re_d   = wr_real;
    im_d   = wr_imag;
    for (int k = 4; k >= 0; k--) begin
      if (accept && used[k] && in_bank_index[k] < 3'd5) begin
        en_d[in_bank_index[k]]   = 1'b1;
        addr_d[in_bank_index[k]] = in_bank_addr[k];
        re_d[in_bank_index[k]]   = in_real[k];
        im_d[in_bank_index[k]]   = in_imag[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      total_q     <= '0;
      wr_en       <= '0;
      wr_addr     <= '0;
      wr_real     <= '0;
      wr_imag     <= '0;
      stage_done  <= 1'b0;
      err_overrun <= 1'b0;
      err_factor  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      total_q     <= total_d;
      wr_en       <= en_d;
      wr_addr     <= addr_d;
      wr_real     <= re_d;
      wr_imag     <= im_d;
      stage_done  <= done_d;
      err_overrun <= ovr_d;
      err_factor  <= fac_d;
    end
  end

  assign busy = (state_q == RUN);

`ifdef MRD_WRBACK_CONFLICT_CHK_EN
  logic hit;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int j = i + 1; j < 5; j++) begin
        if (used[i] && used[j] && in_bank_index[i] < 3'd5 &&
            in_bank_index[i] == in_bank_index[j])
          hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n)
      err_conflict <= 1'b0;
    else if (accept && hit)
      err_conflict <= 1'b1;
  end
`else
  assign err_conflict = 1'b0;
`endif

endmodule

// File: tb/tb_mrd_rdx_wrback.sv
// Scoreboard bench for mrd_rdx_wrback: expected bank writes queued per beat.
// Conflict expectation follows MRD_WRBACK_CONFLICT_CHK_EN.
module tb_mrd_rdx_wrback;

  localparam int WD = 30;
  localparam int WA = 8;
  localparam int WC = 12;
`ifdef MRD_WRBACK_CONFLICT_CHK_EN
  localparam bit CNF_ON = 1'b1;
`else
  localparam bit CNF_ON = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                cfg_start = 1'b0;
  logic [WC-1:0]       cfg_total = '0;
  logic                in_val = 1'b0;
  logic [2:0]          in_factor = '0;
  logic [0:4][2:0]     in_bank_index = '0;
  logic [0:4][WA-1:0]  in_bank_addr = '0;
  logic [0:4][WD-1:0]  in_real = '0;
  logic [0:4][WD-1:0]  in_imag = '0;
  logic [4:0]          wr_en;
  logic [0:4][WA-1:0]  wr_addr;
  logic [0:4][WD-1:0]  wr_real;
  logic [0:4][WD-1:0]  wr_imag;
  logic                busy, stage_done;
  logic                err_overrun, err_factor, err_conflict;

  mrd_rdx_wrback #(.wData(WD), .wAddr(WA), .wCnt(WC)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_total(cfg_total),
    .in_val(in_val), .in_factor(in_factor),
    .in_bank_index(in_bank_index), .in_bank_addr(in_bank_addr),
    .in_real(in_real), .in_imag(in_imag),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_real(wr_real), .wr_imag(wr_imag),
    .busy(busy), .stage_done(stage_done),
    .err_overrun(err_overrun), .err_factor(err_factor),
    .err_conflict(err_conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]         en;
    logic [0:4][WA-1:0] a;
    logic [0:4][WD-1:0] r;
    logic [0:4][WD-1:0] i;
  } exp_t;

  exp_t q[$];
  exp_t sh;
  int total = 0;
  int bad = 0;
  logic exp_ovr = 0, exp_fac = 0, exp_cnf = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rand_lanes();
    for (int k = 0; k < 5; k++) begin
      in_bank_addr[k] = WA'($urandom);
      in_real[k]      = WD'($urandom);
      in_imag[k]      = WD'($urandom);
    end
  endtask

  task automatic set_idx(input int a, input int b, input int c,
                         input int d, input int e);
    in_bank_index[0] = 3'(a);
    in_bank_index[1] = 3'(b);
    in_bank_index[2] = 3'(c);
    in_bank_index[3] = 3'(d);
    in_bank_index[4] = 3'(e);
  endtask

  // acc: bench's own judgement that this beat is written
  task automatic cyc(input bit acc, input bit ed, input bit eb);
    exp_t e;
    bit found;
    if (rst_n) begin
      sh.a = '0; sh.r = '0; sh.i = '0;
    end
    e.en = '0; e.a = sh.a; e.r = sh.r; e.i = sh.i;
    if (acc && !rst_n) begin
      for (int b = 0; b < 5; b++) begin
        found = 0;
        for (int k = 0; k < 5; k++) begin
          if (!found && k < int'(in_factor) &&
              int'(in_bank_index[k]) == b) begin
            found = 1;
            e.en[b] = 1'b1;
            e.a[b] = in_bank_addr[k];
            e.r[b] = in_real[k];
            e.i[b] = in_imag[k];
          end
        end
      end
    end
    sh = e;
    q.push_back(e);
    @(posedge clk);
    #1;
    cfg_start = 0;
    in_val = 0;
    e = q.pop_front();
    chk("wr_en", 64'(wr_en), 64'(e.en));
    for (int b = 0; b < 5; b++) begin
      chk($sformatf("addr%0d", b), 64'(wr_addr[b]), 64'(e.a[b]));
      chk($sformatf("real%0d", b), 64'(wr_real[b]), 64'(e.r[b]));
      chk($sformatf("imag%0d", b), 64'(wr_imag[b]), 64'(e.i[b]));
    end
    chk("busy", 64'(busy), 64'(eb));
    chk("done", 64'(stage_done), 64'(ed));
    chk("ovr", 64'(err_overrun), 64'(exp_ovr));
    chk("fac", 64'(err_factor), 64'(exp_fac));
    chk("cnf", 64'(err_conflict), 64'(exp_cnf));
  endtask

  task automatic beat(input int fac);
    rand_lanes();
    in_val = 1;
    in_factor = 3'(fac);
  endtask

  task automatic start(input int tot);
    cfg_start = 1;
    cfg_total = WC'(tot);
  endtask

  initial begin
    sh.en = '0; sh.a = '0; sh.r = '0; sh.i = '0;
    #2;
    // reset
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    rst_n = 0;
    // total 12, three factor-4 beats
    start(12);      cyc(0, 0, 1);
    set_idx(0, 1, 2, 3, 0);
    beat(4);        cyc(1, 0, 1);
    beat(4);        cyc(1, 0, 1);
    beat(4);        cyc(1, 0, 1);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    // full five-lane permutation
    start(100);     cyc(0, 0, 1);
    set_idx(3, 0, 4, 1, 2);
    beat(5);
    for (int k = 0; k < 5; k++) in_bank_addr[k] = WA'(10 + k);
    cyc(1, 0, 1);
    chk("perm_en", 64'(wr_en), 64'h1f);
    chk("perm_b3", 64'(wr_addr[3]), 64'd10);
    chk("perm_b2", 64'(wr_addr[2]), 64'd14);
    // same-bank lanes, unused lanes must not write
    set_idx(2, 2, 1, 0, 0);
    beat(3);
    exp_cnf = CNF_ON;
    cyc(1, 0, 1);
    chk("cnf_en", 64'(wr_en), 64'h06);
    // out-of-range bank ignored
    set_idx(7, 0, 0, 0, 0);
    beat(2);        cyc(1, 0, 1);
    // restart mid-stage: total 10, then total 6 with 2nd beat
    start(10);      cyc(0, 0, 1);
    set_idx(4, 3, 2, 1, 0);
    beat(4);        cyc(1, 0, 1);
    beat(4); start(6); cyc(1, 0, 1);
    beat(4);
    exp_ovr = 1;
    cyc(1, 0, 1);
    cyc(0, 1, 0);
    // reset mid-stage with a beat in flight
    start(20);      cyc(0, 0, 1);
    beat(4);        cyc(1, 0, 1);
    beat(4);
    rst_n = 1;
    exp_ovr = 0; exp_fac = 0; exp_cnf = 0;
    cyc(0, 0, 0);
    rst_n = 0;
    cyc(0, 0, 0);
    // idle beat, then bad factor inside a stage
    beat(4);
    exp_ovr = 1;
    cyc(0, 0, 0);
    start(8);       cyc(0, 0, 1);
    beat(7);
    exp_fac = 1;
    cyc(0, 0, 1);
    beat(4);        cyc(1, 0, 1);
    beat(4);        cyc(1, 0, 1);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
